// File: rtl/lsu_hs_if.sv
// Request/response handshake bundle between the core memory stage and the load/store unit.
// Signal names follow the LSU port list; master = core side, slave = LSU side.
interface lsu_hs_if #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDRESS_SPACE  = 4096,
  parameter int unsigned NUM_DATA_TYPES = 8
);
  localparam int unsigned AW = $clog2(ADDRESS_SPACE);
  localparam int unsigned TW = $clog2(NUM_DATA_TYPES);

  logic                  req_valid_in;
  logic                  req_ready_out;
  logic [AW-1:0]         addr_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  WE_in;
  logic [TW-1:0]         dtypes_in;
  logic                  rsp_valid_out;
  logic                  rsp_ready_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  misaligned_out;
  logic                  illegal_out;

  modport master (
    output req_valid_in, addr_in, data_in, WE_in, dtypes_in, rsp_ready_in,
    input  req_ready_out, rsp_valid_out, data_out, misaligned_out, illegal_out
  );

  modport slave (
    input  req_valid_in, addr_in, data_in, WE_in, dtypes_in, rsp_ready_in,
    output req_ready_out, rsp_valid_out, data_out, misaligned_out, illegal_out
  );
endinterface

// File: rtl/lsu_hs.sv
// Load/store unit: byte-addressed little-endian data RAM behind a valid/ready handshake,
// one request in flight, sign/zero extension, misalignment and illegal-dtype faults.
module lsu_hs #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDRESS_SPACE  = 4096,
  parameter int unsigned NUM_DATA_TYPES = 8
) (
  input  logic     clk,
  input  logic     reset,
  lsu_hs_if.slave  bus
);
  localparam int unsigned NB   = DATA_WIDTH / 8;
  localparam int unsigned AW   = $clog2(ADDRESS_SPACE);
  localparam int unsigned TW   = $clog2(NUM_DATA_TYPES);
  localparam int unsigned LW   = $clog2(NB);
  localparam int unsigned RW   = AW - LW;
  localparam int unsigned ROWS = ADDRESS_SPACE / NB;

  localparam logic [TW-1:0] DT_B  = TW'(0);
  localparam logic [TW-1:0] DT_H  = TW'(1);
  localparam logic [TW-1:0] DT_W  = TW'(2);
  localparam logic [TW-1:0] DT_BU = TW'(3);
  localparam logic [TW-1:0] DT_HU = TW'(4);
  localparam logic [TW-1:0] DT_D  = TW'(5);
  localparam logic [TW-1:0] DT_WU = TW'(6);
  localparam logic [TW-1:0] DT_IL = TW'(7);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e                state_q;
  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic                  mis_q;
  logic                  ill_q;
  logic [DATA_WIDTH-1:0] data_out_q;

  logic [AW-1:0]         addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  we_q;
  logic [TW-1:0]         dtype_q;
  logic [DATA_WIDTH-1:0] rd_row_q;

  logic [DATA_WIDTH-1:0] mem_q [ROWS];

  logic [7:0]            bmask_c;
  logic [2:0]            amask_c;
  logic                  ill_c;
  logic                  mis_c;
  logic [LW-1:0]         lane_c;
  logic [RW-1:0]         row_c;
  logic [NB-1:0]         be_c;
  logic [DATA_WIDTH-1:0] wr_shift_c;
  logic [DATA_WIDTH-1:0] rd_shift_c;
  logic [DATA_WIDTH-1:0] ld_c;

  // Access decode for the latched request: byte mask, alignment mask, faults, lane data.
  always_comb begin
    bmask_c = 8'h01;
    amask_c = 3'd0;
    case (dtype_q)
      DT_B, DT_BU: begin bmask_c = 8'h01; amask_c = 3'd0; end
      DT_H, DT_HU: begin bmask_c = 8'h03; amask_c = 3'd1; end
      DT_W, DT_WU: begin bmask_c = 8'h0F; amask_c = 3'd3; end
      DT_D:        begin bmask_c = 8'hFF; amask_c = 3'd7; end
      default:     begin bmask_c = 8'h01; amask_c = 3'd0; end
    endcase

    ill_c = (dtype_q == DT_IL) ||
            ((DATA_WIDTH == 32) && ((dtype_q == DT_D) || (dtype_q == DT_WU)));
    mis_c = !ill_c && ((addr_q[2:0] & amask_c) != 3'd0);

    lane_c     = addr_q[LW-1:0];
    row_c      = addr_q[AW-1:LW];
    be_c       = NB'(bmask_c) << lane_c;
    wr_shift_c = wdata_q << {lane_c, 3'b000};
    rd_shift_c = rd_row_q >> {lane_c, 3'b000};

    ld_c = '0;
    case (dtype_q)
      DT_B:    ld_c = DATA_WIDTH'($signed(rd_shift_c[7:0]));
      DT_BU:   ld_c = DATA_WIDTH'(rd_shift_c[7:0]);
      DT_H:    ld_c = DATA_WIDTH'($signed(rd_shift_c[15:0]));
      DT_HU:   ld_c = DATA_WIDTH'(rd_shift_c[15:0]);
      DT_W:    ld_c = DATA_WIDTH'($signed(rd_shift_c[31:0]));
      DT_WU:   ld_c = DATA_WIDTH'(rd_shift_c[31:0]);
      DT_D:    ld_c = rd_shift_c;
      default: ld_c = '0;
    endcase
  end

  // Data RAM: byte-enabled write and registered row read, both in ACCESS; reset blocks the write.
  always_ff @(posedge clk) begin
    if (state_q == ACCESS) begin
      rd_row_q <= mem_q[row_c];
      if (!reset && we_q && !ill_c && !mis_c) begin
        for (int i = 0; i < int'(NB); i++) begin
          if (be_c[i]) mem_q[row_c][8*i +: 8] <= wr_shift_c[8*i +: 8];
        end
      end
    end
  end

  // Control FSM; the first RESP cycle registers the result so outputs appear two edges after acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      mis_q       <= 1'b0;
      ill_q       <= 1'b0;
      data_out_q  <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      dtype_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid_in) begin
            addr_q      <= bus.addr_in;
            wdata_q     <= bus.data_in;
            we_q        <= bus.WE_in;
            dtype_q     <= bus.dtypes_in;
            req_ready_q <= 1'b0;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          state_q <= RESP;
        end
        RESP: begin
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
            ill_q       <= ill_c;
            mis_q       <= mis_c;
            data_out_q  <= (we_q || ill_c || mis_c) ? '0 : ld_c;
          end else if (bus.rsp_ready_in) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready_out  = req_ready_q;
  assign bus.rsp_valid_out  = rsp_valid_q;
  assign bus.data_out       = data_out_q;
  assign bus.misaligned_out = mis_q;
  assign bus.illegal_out    = ill_q;

endmodule

// File: tb/tb_lsu_hs.sv
// Directed bench for lsu_hs: a 32-bit instance for round trips, lanes, faults, backpressure
// and mid-access reset, plus a 64-bit instance for doubleword and word extension.
module tb_lsu_hs;
  localparam logic [2:0] DT_B  = 3'd0;
  localparam logic [2:0] DT_H  = 3'd1;
  localparam logic [2:0] DT_W  = 3'd2;
  localparam logic [2:0] DT_BU = 3'd3;
  localparam logic [2:0] DT_HU = 3'd4;
  localparam logic [2:0] DT_D  = 3'd5;
  localparam logic [2:0] DT_WU = 3'd6;
  localparam logic [2:0] DT_IL = 3'd7;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  lsu_hs_if #(.DATA_WIDTH(32), .ADDRESS_SPACE(4096), .NUM_DATA_TYPES(8)) b32 ();
  lsu_hs_if #(.DATA_WIDTH(64), .ADDRESS_SPACE(4096), .NUM_DATA_TYPES(8)) b64 ();

  lsu_hs #(.DATA_WIDTH(32), .ADDRESS_SPACE(4096), .NUM_DATA_TYPES(8)) u_lsu32 (
    .clk(clk), .reset(reset), .bus(b32)
  );
  lsu_hs #(.DATA_WIDTH(64), .ADDRESS_SPACE(4096), .NUM_DATA_TYPES(8)) u_lsu64 (
    .clk(clk), .reset(reset), .bus(b64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, expected completion)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on the selected instance; returns response fields and edge latency.
  task automatic txn(input bit w64, input bit we, input logic [2:0] dt, input logic [11:0] addr,
                     input logic [63:0] wd, output logic [63:0] rd, output logic mis,
                     output logic ill, output int lat);
    int n;
    if (w64) begin
      b64.req_valid_in = 1'b1; b64.WE_in = we; b64.dtypes_in = dt;
      b64.addr_in = addr; b64.data_in = wd;
    end else begin
      b32.req_valid_in = 1'b1; b32.WE_in = we; b32.dtypes_in = dt;
      b32.addr_in = addr; b32.data_in = wd[31:0];
    end
    n = 0;
    while (!(w64 ? b64.req_ready_out : b32.req_ready_out) && n < 20) begin
      step();
      n++;
    end
    chk("req_ready_wait", 64'(w64 ? b64.req_ready_out : b32.req_ready_out), 64'(1));
    step();
    b32.req_valid_in = 1'b0;
    b64.req_valid_in = 1'b0;
    lat = 0;
    while (!(w64 ? b64.rsp_valid_out : b32.rsp_valid_out) && lat < 20) begin
      step();
      lat++;
    end
    chk("rsp_valid_wait", 64'(w64 ? b64.rsp_valid_out : b32.rsp_valid_out), 64'(1));
    rd  = w64 ? b64.data_out : 64'(b32.data_out);
    mis = w64 ? b64.misaligned_out : b32.misaligned_out;
    ill = w64 ? b64.illegal_out : b32.illegal_out;
    if (w64) b64.rsp_ready_in = 1'b1; else b32.rsp_ready_in = 1'b1;
    step();
    b32.rsp_ready_in = 1'b0;
    b64.rsp_ready_in = 1'b0;
  endtask

  initial begin
    logic [63:0] rd;
    logic        mis;
    logic        ill;
    int          lat;

    reset = 1'b1;
    b32.req_valid_in = 1'b0; b32.rsp_ready_in = 1'b0; b32.addr_in = '0;
    b32.data_in = '0; b32.WE_in = 1'b0; b32.dtypes_in = '0;
    b64.req_valid_in = 1'b0; b64.rsp_ready_in = 1'b0; b64.addr_in = '0;
    b64.data_in = '0; b64.WE_in = 1'b0; b64.dtypes_in = '0;
    step(); step(); step();
    reset = 1'b0;
    step();

    // reset values
    chk("rst_req_ready", 64'(b32.req_ready_out), 64'(1));
    chk("rst_rsp_valid", 64'(b32.rsp_valid_out), 64'(0));
    chk("rst_misaligned", 64'(b32.misaligned_out), 64'(0));
    chk("rst_illegal", 64'(b32.illegal_out), 64'(0));
    chk("rst_data_out", 64'(b32.data_out), 64'(0));
    chk("rst64_req_ready", 64'(b64.req_ready_out), 64'(1));

    // full word round trip with latency
    txn(0, 1, DT_W, 12'h000, 64'hABCDEF00, rd, mis, ill, lat);
    chk("t1_st_lat", 64'(lat), 64'(2));
    chk("t1_st_data", rd, 64'h0);
    chk("t1_st_mis", 64'(mis), 64'(0));
    txn(0, 0, DT_W, 12'h000, 64'h0, rd, mis, ill, lat);
    chk("t1_ld_lat", 64'(lat), 64'(2));
    chk("t1_ld_data", rd, 64'hABCDEF00);
    chk("t1_ready_after", 64'(b32.req_ready_out), 64'(1));

    // sub-word lanes
    txn(0, 1, DT_W, 12'h010, 64'h11223344, rd, mis, ill, lat);
    txn(0, 1, DT_H, 12'h012, 64'h0000FFFF, rd, mis, ill, lat);
    chk("t2_sth_mis", 64'(mis), 64'(0));
    txn(0, 1, DT_B, 12'h011, 64'h00000080, rd, mis, ill, lat);
    txn(0, 0, DT_W, 12'h010, 64'h0, rd, mis, ill, lat);
    chk("t2_ldw", rd, 64'hFFFF8044);
    txn(0, 0, DT_B, 12'h011, 64'h0, rd, mis, ill, lat);
    chk("t2_ldb", rd, 64'hFFFFFF80);
    txn(0, 0, DT_BU, 12'h011, 64'h0, rd, mis, ill, lat);
    chk("t2_ldbu", rd, 64'h00000080);
    txn(0, 0, DT_HU, 12'h012, 64'h0, rd, mis, ill, lat);
    chk("t2_ldhu", rd, 64'h0000FFFF);
    txn(0, 0, DT_H, 12'h010, 64'h0, rd, mis, ill, lat);
    chk("t2_ldh", rd, 64'hFFFF8044);

    // faults
    txn(0, 1, DT_H, 12'h013, 64'h00001234, rd, mis, ill, lat);
    chk("t3_sth_mis", 64'(mis), 64'(1));
    chk("t3_sth_ill", 64'(ill), 64'(0));
    txn(0, 0, DT_W, 12'h010, 64'h0, rd, mis, ill, lat);
    chk("t3_unchanged", rd, 64'hFFFF8044);
    txn(0, 0, DT_W, 12'h00E, 64'h0, rd, mis, ill, lat);
    chk("t3_ldw_mis", 64'(mis), 64'(1));
    chk("t3_ldw_data", rd, 64'h0);
    txn(0, 0, DT_D, 12'h000, 64'h0, rd, mis, ill, lat);
    chk("t3_d32_ill", 64'(ill), 64'(1));
    chk("t3_d32_mis", 64'(mis), 64'(0));
    chk("t3_d32_data", rd, 64'h0);
    txn(0, 0, DT_IL, 12'h001, 64'h0, rd, mis, ill, lat);
    chk("t3_prio_ill", 64'(ill), 64'(1));
    chk("t3_prio_mis", 64'(mis), 64'(0));

    // top row
    txn(0, 1, DT_W, 12'hFFC, 64'hCAFEF00D, rd, mis, ill, lat);
    txn(0, 0, DT_W, 12'hFFC, 64'h0, rd, mis, ill, lat);
    chk("top_row", rd, 64'hCAFEF00D);
    txn(0, 0, DT_B, 12'hFFF, 64'h0, rd, mis, ill, lat);
    chk("top_byte", rd, 64'hFFFFFFCA);

    // backpressure: response held, a queued request waits for the handshake
    b32.req_valid_in = 1'b1; b32.WE_in = 1'b0; b32.dtypes_in = DT_W;
    b32.addr_in = 12'h000; b32.data_in = '0;
    step();
    b32.addr_in = 12'h010;
    chk("bp_ready_drop", 64'(b32.req_ready_out), 64'(0));
    step(); step();
    chk("bp_valid", 64'(b32.rsp_valid_out), 64'(1));
    chk("bp_data", 64'(b32.data_out), 64'hABCDEF00);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_valid", 64'(b32.rsp_valid_out), 64'(1));
      chk("bp_hold_data", 64'(b32.data_out), 64'hABCDEF00);
      chk("bp_hold_ready", 64'(b32.req_ready_out), 64'(0));
    end
    b32.rsp_ready_in = 1'b1;
    step();
    b32.rsp_ready_in = 1'b0;
    chk("bp_valid_drop", 64'(b32.rsp_valid_out), 64'(0));
    chk("bp_ready_back", 64'(b32.req_ready_out), 64'(1));
    step();
    chk("bp_next_accept", 64'(b32.req_ready_out), 64'(0));
    b32.req_valid_in = 1'b0;
    step(); step();
    chk("bp_next_valid", 64'(b32.rsp_valid_out), 64'(1));
    chk("bp_next_data", 64'(b32.data_out), 64'hFFFF8044);
    b32.rsp_ready_in = 1'b1;
    step();
    b32.rsp_ready_in = 1'b0;

    // reset during ACCESS of a store
    txn(0, 1, DT_W, 12'h020, 64'h01020304, rd, mis, ill, lat);
    b32.req_valid_in = 1'b1; b32.WE_in = 1'b1; b32.dtypes_in = DT_W;
    b32.addr_in = 12'h020; b32.data_in = 32'hDEADBEEF;
    step();
    b32.req_valid_in = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid_valid", 64'(b32.rsp_valid_out), 64'(0));
    chk("rst_mid_ready", 64'(b32.req_ready_out), 64'(1));
    step(); step();
    chk("rst_mid_no_rsp", 64'(b32.rsp_valid_out), 64'(0));
    txn(0, 0, DT_W, 12'h020, 64'h0, rd, mis, ill, lat);
    chk("rst_mid_mem", rd, 64'h01020304);

    // 64-bit instance
    txn(1, 1, DT_D, 12'h008, 64'h8000000012345678, rd, mis, ill, lat);
    chk("t6_st_lat", 64'(lat), 64'(2));
    txn(1, 0, DT_D, 12'h008, 64'h0, rd, mis, ill, lat);
    chk("t6_ldd", rd, 64'h8000000012345678);
    txn(1, 0, DT_W, 12'h00C, 64'h0, rd, mis, ill, lat);
    chk("t6_ldw", rd, 64'hFFFFFFFF80000000);
    txn(1, 0, DT_WU, 12'h00C, 64'h0, rd, mis, ill, lat);
    chk("t6_ldwu", rd, 64'h0000000080000000);
    chk("t6_wu_ill", 64'(ill), 64'(0));
    txn(1, 0, DT_H, 12'h00A, 64'h0, rd, mis, ill, lat);
    chk("t6_ldh", rd, 64'h0000000000001234);
    txn(1, 0, DT_D, 12'h004, 64'h0, rd, mis, ill, lat);
    chk("t6_d_mis", 64'(mis), 64'(1));
    chk("t6_d_mis_data", rd, 64'h0);
    txn(1, 0, DT_IL, 12'h000, 64'h0, rd, mis, ill, lat);
    chk("t6_ill", 64'(ill), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
